// File: rtl/aes_spi_responder.sv
// SPI responder in front of an AES core: deserializes a {data, key} frame on SDI,
// runs the core through a start/done handshake, then shifts the 128-bit result out on SDO.
module aes_spi_responder #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 CS,
  input  logic                 SDI,
  output logic                 SDO,
  output logic                 core_start,
  output logic [127:0]         core_data,
  output logic [Nk*32-1:0]     core_key,
  input  logic                 core_done,
  input  logic [127:0]         core_result,
  output logic                 busy,
  output logic                 frame_abort,
  output logic [4:0]           core_rounds,
  output logic [2:0]           state_dbg
);

  localparam int KW    = Nk * 32;
  localparam int FRAME = 128 + KW;
  localparam int CW    = $clog2(FRAME + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RX    = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    TX    = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [FRAME-1:0] rx_shift_q;
  logic [FRAME-1:0] rx_next;
  logic [127:0]     tx_shift_q;
  logic             abort;
  logic             rx_last;
  logic             tx_load;

  // Core handshake: core_start is a single-cycle request; the core answers by holding
  // core_done high with core_result valid. Only the first core_done seen in WAIT is taken.
  assign rx_next     = {rx_shift_q[FRAME-2:0], SDI};
  assign SDO         = (state_q == TX) & tx_shift_q[127];
  assign busy        = (state_q != IDLE);
  assign core_start  = (state_q == START) & ~CS;
  assign core_rounds = 5'(Nr);
  assign state_dbg   = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    rx_last = 1'b0;
    tx_load = 1'b0;
    case (state_q)
      IDLE:  if (!CS) state_d = RX;
      RX: begin
        if (CS) abort = 1'b1;
        else if (cnt_q == CW'(FRAME - 1)) begin
          rx_last = 1'b1;
          state_d = START;
        end
      end
      START: if (CS) abort = 1'b1; else state_d = WAIT;
      WAIT: begin
        if (CS) abort = 1'b1;
        else if (core_done) begin
          tx_load = 1'b1;
          state_d = TX;
        end
      end
      TX: begin
        if (CS) abort = 1'b1;
        else if (cnt_q == CW'(127)) state_d = DONE;
      end
      DONE:    if (CS) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      core_data   <= '0;
      core_key    <= '0;
      frame_abort <= 1'b0;
    end else begin
      frame_abort <= abort;
      case (state_q)
        IDLE: begin
          if (!CS) begin
            rx_shift_q <= rx_next;
            cnt_q      <= CW'(1);
          end
        end
        RX: begin
          if (!CS) begin
            rx_shift_q <= rx_next;
            cnt_q      <= cnt_q + CW'(1);
          end
          if (rx_last) begin
            core_data <= rx_next[FRAME-1 -: 128];
            core_key  <= rx_next[KW-1:0];
          end
        end
        WAIT: begin
          if (tx_load) begin
            tx_shift_q <= core_result;
            cnt_q      <= '0;
          end
        end
        TX: begin
          if (!CS) begin
            tx_shift_q <= {tx_shift_q[126:0], 1'b0};
            cnt_q      <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
      // Every return to IDLE (abort or end of transaction) starts the next frame clean.
      if (state_d == IDLE) begin
        cnt_q      <= '0;
        rx_shift_q <= '0;
        tx_shift_q <= '0;
      end
    end
  end

endmodule

// File: doc/aes_spi_responder.md
Name: aes_spi_responder

Overview:
- SPI responder end of the AES link. It deserializes a {data, key} frame shifted in on SDI while CS is low.
- It hands the frame to an AES core (cipher or inverse cipher) through a start/done handshake.
- It then serializes the 128-bit core result MSB-first on SDO.
- One instance sits in front of each AES core, opposite the existing SPI initiator.

Parameters:
- Nk, 4, key length in 32-bit words (4/6/8). Frame length FRAME = 128 + Nk*32 bits.
- Nr, 10, round count. Passed through for core configuration only; no internal use.

Ports:
- clk  input  1  system clock; all sampling on rising edge
- rst  input  1  asynchronous, active-low reset
- CS  input  1  chip select, active-low
- SDI  input  1  serial data in, MSB-first
- SDO  output  1  serial data out, MSB-first
- core_start  output  1  one-cycle pulse, frame ready for core
- core_data  output  128  received plaintext/ciphertext
- core_key  output  Nk*32  received key
- core_done  input  1  core result valid (level, sampled in WAIT only)
- core_result  input  128  core output, valid when core_done=1
- busy  output  1  high in every state except IDLE
- frame_abort  output  1  one-cycle pulse on CS deassertion mid-transaction

Behaviour:
- Reset (rst=0, async): state IDLE; SDO=0, core_start=0, busy=0, frame_abort=0; core_data=0, core_key=0; bit counter=0; shift registers=0.
- Frame format: bit 0 of the frame is core_data[127]; bit 127 is core_data[0]; bit 128 is core_key[Nk*32-1]; last bit is core_key[0].
- IDLE: on a rising edge with CS=0, sample SDI as frame bit 0, set count=1, go to RX.
- RX: each rising edge with CS=0 shifts SDI in and increments count. The edge sampling bit FRAME-1 transfers the shift register to core_data/core_key and goes to START.
- core_data/core_key are updated only at that transfer. They hold until the next complete frame.
- START: core_start=1 for exactly this one cycle, then go to WAIT.
- WAIT: the first rising edge with core_done=1 loads core_result into the tx shift register and goes to TX. There is no timeout.
- TX: SDO = tx_shift[127]. Shift left one bit per clock for 128 cycles, so result bit 127 is on SDO in the first TX cycle and bit 0 in the 128th. Then go to DONE with SDO=0.
- DONE: hold until CS=1, then go to IDLE. A frame is never restarted while CS is held low.
- Latency: core_start is asserted the cycle after the edge that samples the last frame bit. The first SDO bit appears the cycle after core_done is sampled.
- Abort: CS=1 sampled in RX, START, WAIT or TX does the following:
  - pulse frame_abort for one cycle;
  - return to IDLE and clear the counter and shift registers;
  - drive SDO=0;
  - leave core_data/core_key unchanged.
- Abort during START: core_start is not asserted.
- core_done outside WAIT is ignored.
- SDO is 0 in every state except TX.
- busy=1 in RX, START, WAIT, TX and DONE.
- Counter is sized to hold FRAME; no wrap-around is permitted. The count resets on every entry to IDLE.

Test Plan:
- Nk=4, CS low for 256 bits of {00112233445566778899aabbccddeeff, 000102030405060708090a0b0c0d0e0f}; core_done with 69c4e0d86a7b0430d8cdb78070b4c55a 10 cycles after core_start -> core_data/core_key match, single core_start pulse, SDO bits over 128 cycles reassemble to 69c4e0d8...c55a, then busy stays 1 until CS high.
- CS raised after 100 frame bits -> frame_abort pulses once, busy=0 next cycle, core_start never asserted, core_data/core_key keep their previous values; the following full frame completes normally.
- core_done held high throughout RX with core_result=FFFF...FF, then dropped before START -> ignored; TX starts only on the next core_done in WAIT.
- rst pulled low mid-TX at bit 60 -> SDO, busy and core_start are 0 immediately, without waiting for a clock edge; after release, state is IDLE and a new frame is accepted.
- Nk=8 (Nr=14): 384-bit frame with key 000102...1f -> core_key matches all 256 bits; core_start asserts only after bit 383.
- CS held low continuously after DONE for 50 cycles -> no new RX and SDO=0; CS high for one cycle then low -> a new frame starts at bit 0.
